id_ex_shift_reg: RTL and testbench
==================================

Name: id_ex_shift_reg

Overview:
ID/EX pipeline register for the ALU path, directly upstream of the EX-stage barrel shifter. Captures decoded operands and derives the shifter controls (shift amount, shift type) one stage early, so EX sees registered, glitch-free controls. Valid/ready handshake on both sides with a one-entry skid buffer, so in_ready depends only on registered state. Supports pipeline flush on branch redirect.

Parameters:
XLEN, 32, datapath width; shift amount width is fixed at 5 (log2 XLEN).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  discard all held and incoming entries
in_valid  in  1  decode stage offers an entry
in_ready  out  1  entry accepted when in_valid & in_ready
in_pc  in  XLEN  instruction PC
in_rs1_data  in  XLEN  forwarded rs1 value
in_rs2_data  in  XLEN  forwarded rs2 value
in_imm  in  XLEN  sign-extended immediate
in_funct3  in  3  instruction funct3
in_funct7_5  in  1  instruction bit 30
in_is_imm  in  1  OP-IMM form (operand B = immediate)
in_alu_op  in  1  instruction is OP/OP-IMM
in_rd  in  5  destination register
in_reg_write  in  1  writes rd
out_valid  out  1  EX entry valid
out_ready  in  1  EX accepts entry
out_pc, out_op_a, out_op_b  out  XLEN each  PC, rs1 data, selected operand B
out_shift_amt  out  5  shifter amount
out_shift_type  out  2  00 SLL, 01 SRL, 11 SRA
out_is_shift  out  1  result comes from shifter
out_funct3  out  3  passthrough
out_rd  out  5  passthrough
out_reg_write  out  1  qualified by out_valid

Behaviour:
- Reset: out_valid=0, skid_valid=0, and all out_* data/control fields 0 (out_shift_type=00); in_ready=1 in the first cycle after reset.
- in_ready = ~skid_valid, driven purely from a register; no combinational path from out_ready.
- Latency: an accepted entry appears on out_* the next cycle when the main register is empty or draining (out_ready=1).
- Main register loads when (~out_valid | out_ready):
  - loads from skid if skid_valid, else from input if accepted;
  - out_valid is cleared if neither source is available.
- Skid capture: accepted entry while out_valid & ~out_ready is written to the skid register and skid_valid is set. in_ready falls the next cycle.
- Skid drain: when the main register loads from skid, skid_valid clears; a simultaneous new accept goes into skid in the same cycle.
- Order is strictly FIFO; no entry is lost or duplicated under any in/out stall pattern.
- Operand B: out_op_b = in_is_imm ? in_imm : in_rs2_data.
- Shift decode (computed before the register):
  - is_shift = in_alu_op & (funct3==001 | funct3==101).
  - amt = in_is_imm ? in_imm[4:0] : in_rs2_data[4:0].
  - type: funct3==001 gives 00; funct3==101 gives 01 if funct7_5=0, else 11.
  - When is_shift=0: type=00 and amt=0.
  - Encoding 10 is never produced.
- Flush (priority over everything): out_valid and skid_valid are 0 next cycle, and any same-cycle in_valid is dropped even though in_ready=1. Data fields may keep stale values.
- Reset has priority over flush; reset mid-stall discards the held entries.
- out_reg_write = held reg_write & out_valid.

Decomposition:
- Package ex_pkg: SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b11; F3_SLL=3'b001, F3_SRX=3'b101; entry struct (pc, op_a, op_b, shift fields, funct3, rd, reg_write) shared with the EX/MEM register.
- One combinational sub-module, shift_ctrl_decode: inputs funct3, funct7_5, alu_op, is_imm, imm[4:0], rs2[4:0]; outputs is_shift, amt, type. It is reused by the decode-stage hazard logic.

Test Plan:
- SRAI x1,x2,7 (alu_op=1, funct3=101, funct7_5=1, is_imm=1, imm=0x407), out_ready=1 -> next cycle out_valid=1, shift_type=11, shift_amt=7, op_b=0x407, is_shift=1.
- SLL reg form, rs2_data=0xFFFF_FF23 -> shift_amt=3, shift_type=00; ADD (funct3=000) -> is_shift=0, amt=0, type=00.
- out_ready=0 while in_valid=1 for entries A, B, C -> A held on output, B in skid, in_ready=0 from the cycle after B's accept, C stalls; release out_ready -> outputs A, B, C in order, no gaps once flowing, in_ready returns to 1.
- flush asserted with main and skid full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, the incoming entry never appears.
- rst asserted for 1 cycle mid-stall -> next cycle out_valid=0, skid empty, out_reg_write=0, in_ready=1.
- Random valid/ready throttling over 1000 entries -> output sequence equals input sequence, and every shift field matches the reference decode.

Source files
------------

// File: rtl/id_ex_shift_reg_pkg.sv
// Shared EX-path types: shifter encodings, funct3 codes and the
// ID/EX entry bundle also carried by the EX/MEM register.
package ex_pkg;

    localparam int XLEN   = 32;
    localparam int SAMT_W = 5;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b11;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
        logic [SAMT_W-1:0] shift_amt;
        logic [1:0]        shift_type;
        logic              is_shift;
        logic [2:0]        funct3;
        logic [4:0]        rd;
        logic              reg_write;
    } entry_t;

    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRX);
    endfunction

endpackage

// File: rtl/id_ex_shift_reg_if.sv
// ID/EX handshake bundle: decode-side offer (in_*) and EX-side entry (out_*).
// master = decode/EX environment, slave = the pipeline register.
interface id_ex_shift_reg_if #(
    parameter int XLEN = ex_pkg::XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [2:0]      in_funct3;
    logic            in_funct7_5;
    logic            in_is_imm;
    logic            in_alu_op;
    logic [4:0]      in_rd;
    logic            in_reg_write;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_op_a;
    logic [XLEN-1:0] out_op_b;
    logic [4:0]      out_shift_amt;
    logic [1:0]      out_shift_type;
    logic            out_is_shift;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rd;
    logic            out_reg_write;

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
        output in_funct3, in_funct7_5, in_is_imm, in_alu_op,
        output in_rd, in_reg_write, out_ready,
        input  in_ready, out_valid, out_pc, out_op_a, out_op_b,
        input  out_shift_amt, out_shift_type, out_is_shift,
        input  out_funct3, out_rd, out_reg_write
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
        input  in_funct3, in_funct7_5, in_is_imm, in_alu_op,
        input  in_rd, in_reg_write, out_ready,
        output in_ready, out_valid, out_pc, out_op_a, out_op_b,
        output out_shift_amt, out_shift_type, out_is_shift,
        output out_funct3, out_rd, out_reg_write
    );

endinterface

// File: rtl/id_ex_shift_reg_shift_ctrl_decode.sv
// Combinational shifter-control decode (shared with decode hazard logic).
// In: funct3, funct7_5, alu_op, is_imm, imm[4:0], rs2[4:0]. Out: is_shift, amt, type.
module shift_ctrl_decode
    import ex_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7_5,
    input  logic              i_alu_op,
    input  logic              i_is_imm,
    input  logic [SAMT_W-1:0] i_imm,
    input  logic [SAMT_W-1:0] i_rs2,
    output logic              o_is_shift,
    output logic [SAMT_W-1:0] o_amt,
    output logic [1:0]        o_type
);

    logic w_is_shift;
    logic w_is_right;

    assign w_is_shift = i_alu_op & is_shift_f3(i_funct3);
    assign w_is_right = w_is_shift & (i_funct3 == F3_SRX);

    assign o_is_shift = w_is_shift;

    // Non-shift entries present a zero amount so EX sees a quiet shifter.
    always_comb begin
        o_amt = '0;
        if (w_is_shift) begin
            o_amt = i_is_imm ? i_imm : i_rs2;
        end
    end

    always_comb begin
        o_type = SHIFT_SLL;
        unique case (1'b1)
            (w_is_right & ~i_funct7_5): o_type = SHIFT_SRL;
            (w_is_right &  i_funct7_5): o_type = SHIFT_SRA;
            default:                    o_type = SHIFT_SLL;
        endcase
    end

endmodule

// File: rtl/id_ex_shift_reg.sv
// ID/EX register for the ALU path with one-entry skid buffer and flush.
// Ports: clk, rst (sync, active-high), flush, bus (slave: in_* offer, out_* entry).
module id_ex_shift_reg
    import ex_pkg::*;
#(
    parameter int XLEN = ex_pkg::XLEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    id_ex_shift_reg_if.slave   bus
);

    logic              w_is_shift;
    logic [SAMT_W-1:0] w_amt;
    logic [1:0]        w_type;
    logic [XLEN-1:0]   w_op_b;
    logic              w_accept;
    logic              w_load;
    entry_t            w_entry;

    entry_t            r_main;
    entry_t            r_skid;
    logic              r_out_valid;
    logic              r_skid_valid;

    shift_ctrl_decode u_dec (
        .i_funct3   (bus.in_funct3),
        .i_funct7_5 (bus.in_funct7_5),
        .i_alu_op   (bus.in_alu_op),
        .i_is_imm   (bus.in_is_imm),
        .i_imm      (bus.in_imm[SAMT_W-1:0]),
        .i_rs2      (bus.in_rs2_data[SAMT_W-1:0]),
        .o_is_shift (w_is_shift),
        .o_amt      (w_amt),
        .o_type     (w_type)
    );

    assign w_op_b = bus.in_is_imm ? bus.in_imm : bus.in_rs2_data;

    always_comb begin
        w_entry            = '0;
        w_entry.pc         = bus.in_pc;
        w_entry.op_a       = bus.in_rs1_data;
        w_entry.op_b       = w_op_b;
        w_entry.shift_amt  = w_amt;
        w_entry.shift_type = w_type;
        w_entry.is_shift   = w_is_shift;
        w_entry.funct3     = bus.in_funct3;
        w_entry.rd         = bus.in_rd;
        w_entry.reg_write  = bus.in_reg_write;
    end

    // Ready comes only from the skid flag, never from out_ready.
    assign bus.in_ready = ~r_skid_valid;

    // A flush drops the offer even when in_ready is high.
    assign w_accept = bus.in_valid & ~r_skid_valid & ~flush;
    assign w_load   = ~r_out_valid | bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load) begin
            if (r_skid_valid) begin
                // Skid is older than any new offer, so it goes first.
                r_main       <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid <= w_entry;
                end
            end else if (w_accept) begin
                r_main      <= w_entry;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_entry;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.out_pc         = r_main.pc;
    assign bus.out_op_a       = r_main.op_a;
    assign bus.out_op_b       = r_main.op_b;
    assign bus.out_shift_amt  = r_main.shift_amt;
    assign bus.out_shift_type = r_main.shift_type;
    assign bus.out_is_shift   = r_main.is_shift;
    assign bus.out_funct3     = r_main.funct3;
    assign bus.out_rd         = r_main.rd;
    assign bus.out_reg_write  = r_main.reg_write & r_out_valid;

endmodule

// File: tb/tb_id_ex_shift_reg.sv
// Bench for id_ex_shift_reg: decode table, stall/flush/reset sequences,
// and randomized throttling against a queue-based reference model.
module tb_id_ex_shift_reg;
    import ex_pkg::*;

    localparam int N_RAND  = 1000;
    localparam int MAX_CYC = 20000;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    id_ex_shift_reg_if bus ();

    id_ex_shift_reg dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [2:0]  f3;
        logic        f7, is_imm, alu, rw;
        logic [4:0]  rd;
    } in_t;

    typedef struct {
        logic [31:0] pc, a, b;
        logic [4:0]  amt;
        logic [1:0]  ty;
        logic        sh;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    typedef struct {
        in_t         x;
        logic        sh;
        logic [4:0]  amt;
        logic [1:0]  ty;
        logic [31:0] b;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RV32I rules: SLL/SRL/SRA by funct3 and bit 30, amount = low 5 bits.
    function automatic exp_t ref_model(input in_t x);
        exp_t e;
        int   f3;
        bit   sh;
        logic [31:0] src;
        f3    = int'(x.f3);
        sh    = x.alu && (f3 == 1 || f3 == 5);
        src   = x.is_imm ? x.imm : x.rs2;
        e.pc  = x.pc;
        e.a   = x.rs1;
        e.b   = src;
        e.sh  = sh;
        e.amt = sh ? 5'(src % 32) : 5'd0;
        if (!sh || f3 == 1) e.ty = 2'd0;
        else if (x.f7)      e.ty = 2'd3;
        else                e.ty = 2'd1;
        e.f3  = x.f3;
        e.rd  = x.rd;
        e.rw  = x.rw;
        return e;
    endfunction

    function automatic logic [127:0] pack_exp(input exp_t e);
        return 128'({e.pc, e.a, e.b, e.amt, e.ty, e.sh, e.f3, e.rd, e.rw});
    endfunction

    function automatic logic [127:0] pack_out();
        return 128'({bus.out_pc, bus.out_op_a, bus.out_op_b,
                     bus.out_shift_amt, bus.out_shift_type,
                     bus.out_is_shift, bus.out_funct3, bus.out_rd,
                     bus.out_reg_write});
    endfunction

    task automatic drive(input in_t x, input logic v);
        bus.in_valid     = v;
        bus.in_pc        = x.pc;
        bus.in_rs1_data  = x.rs1;
        bus.in_rs2_data  = x.rs2;
        bus.in_imm       = x.imm;
        bus.in_funct3    = x.f3;
        bus.in_funct7_5  = x.f7;
        bus.in_is_imm    = x.is_imm;
        bus.in_alu_op    = x.alu;
        bus.in_rd        = x.rd;
        bus.in_reg_write = x.rw;
    endtask

    function automatic in_t mk(input logic [31:0] tag);
        in_t x;
        x.pc = tag; x.rs1 = tag + 1; x.rs2 = tag + 2; x.imm = tag + 3;
        x.f3 = 3'd0; x.f7 = 1'b0; x.is_imm = 1'b0; x.alu = 1'b1;
        x.rw = 1'b1; x.rd = tag[4:0];
        return x;
    endfunction

    function automatic in_t rnd(input int idx);
        in_t x;
        x.pc = 32'(idx) * 4; x.rs1 = $urandom; x.rs2 = $urandom;
        x.imm = $urandom; x.f3 = 3'($urandom_range(0, 7));
        x.f7 = 1'($urandom); x.is_imm = 1'($urandom);
        x.alu = ($urandom_range(0, 3) != 0);
        x.rw = 1'($urandom); x.rd = 5'($urandom);
        return x;
    endfunction

    function automatic vec_t mkv(input logic [2:0] f3, input logic f7,
        input logic alu, input logic ii, input logic [31:0] imm,
        input logic [31:0] rs2, input logic sh, input logic [4:0] amt,
        input logic [1:0] ty, input logic [31:0] b);
        vec_t v;
        v.x = mk(32'h100);
        v.x.f3 = f3; v.x.f7 = f7; v.x.alu = alu; v.x.is_imm = ii;
        v.x.imm = imm; v.x.rs2 = rs2;
        v.sh = sh; v.amt = amt; v.ty = ty; v.b = b;
        return v;
    endfunction

    task automatic idle();
        in_t z;
        z = mk(32'h0);
        drive(z, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[8];
    exp_t q[$];
    exp_t e;
    in_t  xa, xb, xc, xd;

    initial begin
        tbl[0] = mkv(3'b101, 1, 1, 1, 32'h407, 32'h55, 1, 7, 2'b11, 32'h407);
        tbl[1] = mkv(3'b001, 0, 1, 0, 32'h9, 32'hFFFF_FF23, 1, 3, 2'b00, 32'hFFFF_FF23);
        tbl[2] = mkv(3'b000, 0, 1, 0, 32'h9, 32'h1F, 0, 0, 2'b00, 32'h1F);
        tbl[3] = mkv(3'b101, 0, 1, 0, 32'h9, 32'h1F, 1, 31, 2'b01, 32'h1F);
        tbl[4] = mkv(3'b101, 0, 1, 1, 32'h25, 32'h3, 1, 5, 2'b01, 32'h25);
        tbl[5] = mkv(3'b101, 1, 0, 1, 32'h407, 32'h3, 0, 0, 2'b00, 32'h407);
        tbl[6] = mkv(3'b101, 1, 1, 0, 32'h9, 32'h20, 1, 0, 2'b11, 32'h20);
        tbl[7] = mkv(3'b001, 0, 1, 1, 32'hFFFF_FFFF, 32'h4, 1, 31, 2'b00, 32'hFFFF_FFFF);

        do_reset();
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_fields", pack_out(), 128'(0));

        // Single-entry decode vectors, EX always ready.
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].x, 1'b1);
            bus.out_ready = 1'b1;
            @(negedge clk);
            idle();
            chk($sformatf("vec%0d_valid", i), 128'(bus.out_valid), 128'(1));
            chk($sformatf("vec%0d_ctl", i),
                128'({bus.out_is_shift, bus.out_shift_amt, bus.out_shift_type}),
                128'({tbl[i].sh, tbl[i].amt, tbl[i].ty}));
            chk($sformatf("vec%0d_opb", i), 128'(bus.out_op_b), 128'(tbl[i].b));
        end
        @(negedge clk);
        chk("vec_drained", 128'(bus.out_valid), 128'(0));

        // Stall: A held, B in skid, C waits; then drain in order.
        xa = mk(32'hA0); xb = mk(32'hB0); xc = mk(32'hC0);
        bus.out_ready = 1'b0;
        drive(xa, 1'b1);
        @(negedge clk);
        chk("stall_a_out", 128'({bus.out_valid, bus.out_pc}), 128'({1'b1, 32'hA0}));
        chk("stall_rdy1", 128'(bus.in_ready), 128'(1));
        drive(xb, 1'b1);
        @(negedge clk);
        chk("stall_rdy0", 128'(bus.in_ready), 128'(0));
        drive(xc, 1'b1);
        @(negedge clk);
        chk("stall_hold_a", 128'({bus.in_ready, bus.out_pc}), 128'({1'b0, 32'hA0}));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("drain_b", 128'({bus.out_valid, bus.out_pc}), 128'({1'b1, 32'hB0}));
        chk("drain_rdy", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        idle();
        chk("drain_c", 128'({bus.out_valid, bus.out_pc}), 128'({1'b1, 32'hC0}));
        @(negedge clk);
        chk("drain_empty", 128'({bus.out_valid, bus.in_ready}), 128'({1'b0, 1'b1}));

        // Flush with main + skid full and an offer present.
        xd = mk(32'hD0);
        bus.out_ready = 1'b0;
        drive(xa, 1'b1);
        @(negedge clk);
        drive(xb, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        drive(xd, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        chk("flush_full", 128'({bus.out_valid, bus.in_ready}), 128'({1'b0, 1'b1}));
        @(negedge clk);
        chk("flush_full_gone", 128'(bus.out_valid), 128'(0));

        // Flush while in_ready=1: the offered entry is dropped.
        bus.out_ready = 1'b0;
        drive(xa, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        drive(xd, 1'b1);
        chk("flush_rdy_high", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        chk("flush_drop", 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        chk("flush_drop_late", 128'(bus.out_valid), 128'(0));

        // Reset mid-stall discards both held entries.
        bus.out_ready = 1'b0;
        drive(xa, 1'b1);
        @(negedge clk);
        drive(xb, 1'b1);
        @(negedge clk);
        idle();
        chk("pre_rst_rw", 128'(bus.out_reg_write), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst", 128'({bus.out_valid, bus.in_ready, bus.out_reg_write}),
            128'({1'b0, 1'b1, 1'b0}));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_empty", 128'(bus.out_valid), 128'(0));

        // Randomized throttling against the queue model.
        begin
            int sent = 0;
            int got  = 0;
            int cyc  = 0;
            int errs = 0;
            logic v;
            in_t  x;
            while ((sent < N_RAND || q.size() != 0) && cyc < MAX_CYC) begin
                @(negedge clk);
                cyc++;
                x = rnd(sent);
                v = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
                drive(x, v);
                bus.out_ready = ($urandom_range(0, 2) != 0);
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        chk("rand_spurious", 128'(bus.out_pc), 128'hX);
                        errs++;
                    end else begin
                        e = q.pop_front();
                        total++;
                        if (pack_out() !== pack_exp(e)) begin
                            bad++;
                            errs++;
                            if (errs < 10)
                                $display("FAIL rand_entry%0d actual=%h required=%h",
                                         got, pack_out(), pack_exp(e));
                        end
                        got++;
                    end
                end
                if (v && bus.in_ready) begin
                    q.push_back(ref_model(x));
                    sent++;
                end
            end
            idle();
            chk("rand_count", 128'(got), 128'(N_RAND));
            chk("rand_leftover", 128'(q.size()), 128'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
